// File: rtl/servo_pwm_decoder.sv
// Four-channel servo pulse-width decoder: measures each channel's high time with
// counters and turns it into an 8-bit duty code, flagging channels that go quiet.
module servo_pwm_decoder #(
  parameter int MIN_TICKS      = 50000,
  parameter int STEP_TICKS     = 196,
  parameter int MAX_HIGH_TICKS = 125000,
  parameter int TIMEOUT_TICKS  = 1250000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] PWMIn,
  input  logic [1:0] channelselect,
  output logic [7:0] duty,
  output logic [3:0] newdata,
  output logic [3:0] lost
);

  localparam int NCH = 4;
  localparam logic [16:0] W_MIN     = 17'(MIN_TICKS);
  localparam logic [16:0] W_MAX     = 17'(MAX_HIGH_TICKS);
  localparam logic [7:0]  STEP_LAST = 8'(STEP_TICKS - 1);
  localparam logic [20:0] TMO_MAX   = 21'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    STUCK = 2'd2
  } state_t;

  function automatic logic [16:0] width_sat_inc(input logic [16:0] v);
    return (v == '1) ? v : v + 17'd1;
  endfunction

  function automatic logic [7:0] code_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [20:0] tmo_sat_inc(input logic [20:0] v);
    return (v >= TMO_MAX) ? TMO_MAX : v + 21'd1;
  endfunction

  logic        v1, v2;
  logic [3:0]  s1, s2, h, armed;
  logic [3:0]  rise, fall, start, latch;
  state_t      state     [NCH];
  state_t      state_nxt [NCH];
  logic [16:0] wcnt      [NCH];
  logic [16:0] wcnt_inc  [NCH];
  logic [7:0]  step      [NCH];
  logic [7:0]  acc       [NCH];
  logic [7:0]  duty_q    [NCH];
  logic [20:0] tmo       [NCH];

  // A channel only measures once its synchronized pin has been seen low after
  // reset, so a pin already high at release is not mistaken for a rising edge.
  assign rise = s2 & ~h & armed;
  assign fall = ~s2 & h;
  assign duty = duty_q[channelselect];

  always_comb begin
    start = '0;
    latch = '0;
    for (int i = 0; i < NCH; i++) begin
      state_nxt[i] = state[i];
      wcnt_inc[i]  = width_sat_inc(wcnt[i]);
      case (state[i])
        IDLE: begin
          if (rise[i]) begin
            start[i]     = 1'b1;
            state_nxt[i] = HIGH;
          end
        end
        HIGH: begin
          if (fall[i]) begin
            latch[i]     = (wcnt[i] <= W_MAX);
            state_nxt[i] = IDLE;
          end else if (s2[i] && (wcnt_inc[i] > W_MAX)) begin
            state_nxt[i] = STUCK;
          end
        end
        STUCK: begin
          if (fall[i]) state_nxt[i] = IDLE;
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      s1      <= '0;
      s2      <= '0;
      h       <= '0;
      armed   <= '0;
      newdata <= '0;
      lost    <= '1;
      for (int i = 0; i < NCH; i++) begin
        state[i]  <= IDLE;
        wcnt[i]   <= '0;
        step[i]   <= '0;
        acc[i]    <= '0;
        duty_q[i] <= '0;
        tmo[i]    <= '0;
      end
    end else begin
      // synchronizer / edge-history stage
      v1      <= 1'b1;
      v2      <= v1;
      s1      <= PWMIn;
      s2      <= s1;
      h       <= s2;
      armed   <= armed | ({NCH{v2}} & ~s2);
      newdata <= latch;
      // measurement stage: the rise cycle counts as the first high clock
      for (int i = 0; i < NCH; i++) begin
        state[i] <= state_nxt[i];
        if (start[i]) begin
          wcnt[i] <= 17'd1;
          step[i] <= '0;
          acc[i]  <= '0;
        end else if ((state[i] == HIGH) && s2[i]) begin
          wcnt[i] <= wcnt_inc[i];
          if (wcnt[i] >= W_MIN) begin
            if (step[i] == STEP_LAST) begin
              step[i] <= '0;
              acc[i]  <= code_sat_inc(acc[i]);
            end else begin
              step[i] <= step[i] + 8'd1;
            end
          end
        end
        if (latch[i]) begin
          duty_q[i] <= acc[i];
          tmo[i]    <= '0;
          lost[i]   <= 1'b0;
        end else begin
          tmo[i] <= tmo_sat_inc(tmo[i]);
          if (tmo_sat_inc(tmo[i]) == TMO_MAX) lost[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder: scaled-down timing parameters, a pulse-level
// reference model, directed frames for the key cases and randomized frames.
`timescale 1ns/1ps
module tb_servo_pwm_decoder;

  localparam int MIN  = 40;
  localparam int STEP = 3;
  localparam int MAXH = 850;
  localparam int TMO  = 2500;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pins  = '0;
  logic [1:0] sel   = '0;
  logic [7:0] duty;
  logic [3:0] newdata;
  logic [3:0] lost;

  int checks   = 0;
  int failures = 0;

  servo_pwm_decoder #(
    .MIN_TICKS     (MIN),
    .STEP_TICKS    (STEP),
    .MAX_HIGH_TICKS(MAXH),
    .TIMEOUT_TICKS (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .PWMIn        (pins),
    .channelselect(sel),
    .duty         (duty),
    .newdata      (newdata),
    .lost         (lost)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int code_of(input int hw);
    int q;
    if (hw < MIN) return 0;
    q = (hw - MIN) / STEP;
    return (q > 255) ? 255 : q;
  endfunction

  // Reference model: works on whole pulses seen as runs of high samples.
  int         run [4];
  bit         run_ok [4];
  bit         seen_low [4];
  bit         prev [4];
  int         pend_at [4];
  int         pend_code [4];
  int         last_latch [4];
  int         cyc;
  logic [7:0] exp_duty [4];
  logic [3:0] exp_nd;
  logic [3:0] exp_lost;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        cyc      = 0;
        exp_nd   = '0;
        exp_lost = '1;
        for (int c = 0; c < 4; c++) begin
          run[c] = 0; run_ok[c] = 0; seen_low[c] = 0; prev[c] = 0;
          pend_at[c] = -1; pend_code[c] = 0; last_latch[c] = -1;
          exp_duty[c] = 8'h00;
        end
      end else begin
        cyc++;
        exp_nd = '0;
        for (int c = 0; c < 4; c++) begin
          if (pend_at[c] == cyc) begin
            exp_duty[c]   = 8'(pend_code[c]);
            exp_nd[c]     = 1'b1;
            last_latch[c] = cyc;
            pend_at[c]    = -1;
          end
          if (pins[c]) begin
            if (!prev[c]) begin
              run_ok[c] = seen_low[c];
              run[c]    = 0;
            end
            run[c]++;
          end else begin
            if (prev[c] && run_ok[c] && (run[c] <= MAXH)) begin
              pend_at[c]   = cyc + 2;
              pend_code[c] = code_of(run[c]);
            end
            seen_low[c] = 1;
            run_ok[c]   = 0;
          end
          prev[c]     = pins[c];
          exp_lost[c] = (last_latch[c] < 0) || ((cyc - last_latch[c]) >= TMO);
        end
      end
    end
  end

  // Per-cycle compare plus event bookkeeping for the directed checks.
  int nd_cnt [4] = '{0, 0, 0, 0};
  int ncyc       = 0;
  int nd3_at     = -1;
  int lost3_at   = -1;
  bit lost3_prev = 1'b1;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        ncyc++;
        chk("duty_vs_model", 32'(duty), 32'(exp_duty[sel]));
        chk("newdata_vs_model", 32'(newdata), 32'(exp_nd));
        chk("lost_vs_model", 32'(lost), 32'(exp_lost));
        for (int c = 0; c < 4; c++) if (newdata[c]) nd_cnt[c]++;
        if (newdata[3]) nd3_at = ncyc;
        if (lost[3] && !lost3_prev) lost3_at = ncyc;
        lost3_prev = lost[3];
      end else begin
        lost3_prev = 1'b1;
      end
    end
  end

  task automatic frame(input int w[4], input int o[4], input int len, input bit rsel);
    for (int t = 0; t < len; t++) begin
      @(negedge clock);
      #1;
      for (int c = 0; c < 4; c++) pins[c] = (t >= o[c]) && (t < o[c] + w[c]);
      if (rsel) sel = 2'($urandom_range(0, 3));
    end
    pins = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
      pins = '0;
    end
  endtask

  task automatic chk_duty(input string nm, input int ch, input logic [7:0] exp);
    @(negedge clock);
    #1;
    sel = 2'(ch);
    #2;
    chk(nm, 32'(duty), 32'(exp));
  endtask

  int base [4];

  task automatic chk_nd(input string nm, input int ch, input int exp_delta);
    chk(nm, nd_cnt[ch] - base[ch], exp_delta);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w[4];
    int o[4];
    int r;

    // Reset values
    repeat (3) @(negedge clock);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("reset_duty", 32'(duty), 32'h00);
    end
    chk("reset_newdata", 32'(newdata), 32'h0);
    chk("reset_lost", 32'(lost), 32'hF);
    @(negedge clock);
    #1 reset = 1'b0;
    idle(5);
    chk("lost_before_pulse", 32'(lost), 32'hF);

    // Nominal mid-scale frames on every channel
    for (int f = 0; f < 2; f++) begin
      base = nd_cnt;
      frame('{422, 422, 422, 422}, '{5, 5, 5, 5}, 1200, 1'b1);
      for (int c = 0; c < 4; c++) begin
        chk_nd("nd_once_per_frame", c, 1);
        chk_duty("duty_mid", c, 8'h7F);
      end
      chk("lost_cleared", 32'(lost), 32'h0);
    end

    // Distinct widths: exact minimum, saturated, short, ten steps
    frame('{40, 840, 20, 70}, '{3, 9, 15, 21}, 900, 1'b1);
    chk_duty("duty_min", 0, 8'h00);
    chk_duty("duty_sat", 1, 8'hFF);
    chk_duty("duty_short", 2, 8'h00);
    chk_duty("duty_10", 3, 8'h0A);

    // Longest accepted pulse, one clock too long, and a long stuck pulse
    base = nd_cnt;
    frame('{850, 851, 880, 422}, '{4, 4, 4, 4}, 900, 1'b1);
    chk_nd("nd_at_max", 0, 1);
    chk_nd("nd_over_max", 1, 0);
    chk_nd("nd_stuck", 2, 0);
    chk_duty("duty_at_max", 0, 8'hFF);
    chk_duty("duty_hold_over", 1, 8'hFF);
    chk_duty("duty_hold_stuck", 2, 8'h00);
    frame('{422, 422, 422, 805}, '{4, 4, 4, 4}, 900, 1'b1);
    chk_duty("duty_after_stuck", 2, 8'h7F);
    chk_duty("duty_ch3_ff", 3, 8'hFF);

    // Signal loss on channel 3
    lost3_at = -1;
    idle(TMO + 60);
    chk("lost3_delay", lost3_at - nd3_at, TMO);
    chk("lost3_set", 32'(lost[3]), 32'h1);
    chk_duty("duty_hold_lost", 3, 8'hFF);
    frame('{0, 0, 0, 100}, '{5, 5, 5, 5}, 200, 1'b0);
    chk("lost3_cleared", 32'(lost[3]), 32'h0);
    chk_duty("duty_after_lost", 3, 8'h14);

    // Reset in the middle of a channel 1 pulse
    @(negedge clock);
    #1 pins[1] = 1'b1;
    repeat (200) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset_newdata", 32'(newdata), 32'h0);
    chk("midreset_lost", 32'(lost), 32'hF);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("midreset_duty", 32'(duty), 32'h00);
    end
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    repeat (222) @(negedge clock);
    #1 pins[1] = 1'b0;
    base = nd_cnt;
    idle(30);
    chk_nd("nd_discarded", 1, 0);
    chk("lost1_after_discard", 32'(lost[1]), 32'h1);
    frame('{0, 422, 0, 0}, '{5, 5, 5, 5}, 500, 1'b0);
    chk_nd("nd_after_reset", 1, 1);
    chk_duty("duty_after_reset", 1, 8'h7F);
    chk("lost1_after_reset", 32'(lost[1]), 32'h0);

    // Latency from the first low sample to the strobe
    @(negedge clock);
    #1 pins[0] = 1'b1;
    repeat (100) @(negedge clock);
    #1 pins[0] = 1'b0;
    @(posedge clock); #1 chk("lat_edge0", 32'(newdata[0]), 32'h0);
    @(posedge clock); #1 chk("lat_edge1", 32'(newdata[0]), 32'h0);
    @(posedge clock); #1 chk("lat_edge2", 32'(newdata[0]), 32'h1);
    @(posedge clock); #1 chk("lat_edge3", 32'(newdata[0]), 32'h0);
    chk_duty("duty_latency", 0, 8'h14);

    // Randomized frames with independent per-channel widths and phases
    for (int f = 0; f < 25; f++) begin
      for (int c = 0; c < 4; c++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      w[c] = 0;
        else if (r == 1) w[c] = MAXH - 1 + $urandom_range(0, 2);
        else             w[c] = $urandom_range(1, 880);
        o[c] = $urandom_range(1, 60);
      end
      frame(w, o, 960, 1'b1);
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
